// File: rtl/rs232c_pkg.sv
// Shared types and constants for the RS-232C receive path.
package rs232c_pkg;

  // 100 MHz system clock / 115200 baud.
  localparam logic [15:0] DEFAULT_WAIT_COUNT = 16'd868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module rx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       overflow_pulse
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign empty          = (count_q == '0);
  assign full           = (count_q == FULL_COUNT);
  assign do_pop         = pop && !empty;
  assign do_push        = push && (!full || do_pop);
  assign overflow_pulse = push && full && !do_pop;
  assign head           = empty ? 8'h00 : mem[rd_ptr_q];

  // NOTE: the storage array has no reset; clearing the pointers and count is
  // enough to discard its contents, and keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/rs232c_rx_fifo.sv
// 8N1 serial receiver feeding a FWFT byte FIFO that drives the core's rx port.
// Define RS232C_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module rs232c_rx_fifo
  import rs232c_pkg::*;
#(
  parameter logic [15:0] WAIT_COUNT = DEFAULT_WAIT_COUNT,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] received_data,
  output logic       waiting,
  input  logic       pop,
  output logic       overrun,
  output logic       framing_error
`ifdef RS232C_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam logic [15:0] HALF_LAST = WAIT_COUNT / 16'd2 - 16'd1;
  localparam logic [15:0] BIT_LAST  = WAIT_COUNT - 16'd1;

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        overrun_q, framing_q, framing_set;
  logic        overflow_pulse, fifo_empty, unused_fifo_full;
  logic        rx_s;
`ifdef RS232C_RX_PARITY_EN
  logic        parity_bit_q, parity_bit_d;
  logic        parity_q, parity_set;
`endif

  assign rx_s = sync2_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    framing_set = 1'b0;
`ifdef RS232C_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
`ifdef RS232C_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef RS232C_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          parity_bit_d = rx_s;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          state_d     = IDLE;
          framing_set = !rx_s;
`ifdef RS232C_RX_PARITY_EN
          parity_set = (parity_bit_q != ^shift_q);
          push_d     = rx_s && !parity_set;
`else
          push_d     = rx_s;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
`ifdef RS232C_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      overrun_q <= overrun_q | overflow_pulse;
      framing_q <= framing_q | framing_set;
`ifdef RS232C_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_q     <= parity_q | parity_set;
`endif
    end
  end

  // shift_q holds the byte until the next frame's first data sample, well after push_q.
  rx_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push_q),
    .push_data     (shift_q),
    .pop           (pop),
    .head          (received_data),
    .empty         (fifo_empty),
    .full          (unused_fifo_full),
    .overflow_pulse(overflow_pulse)
  );

  assign waiting       = fifo_empty;
  assign overrun       = overrun_q;
  assign framing_error = framing_q;
`ifdef RS232C_RX_PARITY_EN
  assign parity_error  = parity_q;
`endif

endmodule

// File: tb/tb_rs232c_rx_fifo.sv
// Directed bench for rs232c_rx_fifo at 16 clocks per bit and a 16-entry FIFO.
module tb_rs232c_rx_fifo;

  localparam logic [15:0] WC = 16'd16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       pop = 1'b0;
  logic [7:0] received_data;
  logic       waiting, overrun, framing_error;
`ifdef RS232C_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs232c_rx_fifo #(
    .WAIT_COUNT(WC),
    .DEPTH_LOG2(4)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .rx           (rx),
    .received_data(received_data),
    .waiting      (waiting),
    .pop          (pop),
    .overrun      (overrun),
    .framing_error(framing_error)
`ifdef RS232C_RX_PARITY_EN
    ,
    .parity_error (parity_error)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Stop-bit tick 11 is the push cycle: stop sample edge + 1.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input bit pop_in_push, input bit chk_lat);
    logic unused_par;
    unused_par = par_b;
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) tick();
    end
`ifdef RS232C_RX_PARITY_EN
    rx = par_b;
    repeat (16) tick();
`endif
    rx = stop_b;
    for (int k = 0; k < 16; k++) begin
      if (k == 11) begin
        if (chk_lat) check("latency_before_push", waiting, 1);
        if (pop_in_push) pop = 1'b1;
      end
      if (k == 12) begin
        pop = 1'b0;
        if (chk_lat) check("latency_after_push", waiting, 0);
      end
      tick();
    end
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_b);
    check({tag, "_waiting"}, waiting, 0);
    check({tag, "_data"}, received_data, exp_b);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    pop   = 1'b0;
    #1;
    check("rst_waiting", waiting, 1);
    check("rst_data", received_data, 8'h00);
    check("rst_overrun", overrun, 0);
    check("rst_framing", framing_error, 0);
`ifdef RS232C_RX_PARITY_EN
    check("rst_parity", parity_error, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    idle(4);
  endtask

  initial begin
    #2;
    do_reset();

    // Single byte with push latency, pop, then pop on empty is ignored.
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 1'b1);
    pop_check("single", 8'h5A);
    check("single_empty", waiting, 1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("pop_empty_ignored", waiting, 1);

    // Burst ordering.
    send_frame(8'h01, 1'b1, ^8'h01, 1'b0, 1'b0);
    send_frame(8'h80, 1'b1, ^8'h80, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, 1'b0);
    pop_check("burst0", 8'h01);
    pop_check("burst1", 8'h80);
    pop_check("burst2", 8'hFF);
    check("burst_empty", waiting, 1);
    check("burst_no_overrun", overrun, 0);

    // Overrun: 17 frames into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send_frame(i[7:0], 1'b1, ^i[7:0], 1'b0, 1'b0);
    check("overrun_set", overrun, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovr%0d", i), i[7:0]);
    check("overrun_drained", waiting, 1);

    // Full FIFO with pop in the push cycle.
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'h20 + i[7:0], 1'b1, ^(8'h20 + i[7:0]), 1'b0, 1'b0);
    send_frame(8'h30, 1'b1, ^8'h30, 1'b1, 1'b0);
    check("fullpp_no_overrun", overrun, 0);
    for (int i = 1; i <= 16; i++) pop_check($sformatf("fullpp%0d", i), 8'h20 + i[7:0]);
    check("fullpp_drained", waiting, 1);

    // False start glitch, framing error, then recovery.
    rx = 1'b0;
    repeat (3) tick();
    idle(40);
    check("glitch_waiting", waiting, 1);
    check("glitch_framing", framing_error, 0);
    check("glitch_overrun", overrun, 0);
    send_frame(8'h33, 1'b0, ^8'h33, 1'b0, 1'b0);
    idle(20);
    check("framing_set", framing_error, 1);
    check("framing_dropped", waiting, 1);
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, 1'b0);
    pop_check("after_framing", 8'hC3);

    // Reset during data bit 4 with a byte buffered and framing_error set.
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 5; i++) begin
      rx = (i % 2 == 1);
      repeat ((i == 4) ? 8 : 16) tick();
    end
    do_reset();
    idle(20);
    send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0, 1'b0);
    pop_check("after_reset", 8'h7E);
    check("after_reset_empty", waiting, 1);

`ifdef RS232C_RX_PARITY_EN
    do_reset();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    pop_check("parity_good", 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("parity_err_set", parity_error, 1);
    check("parity_dropped", waiting, 1);
    check("parity_no_framing", framing_error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
